// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin pipelined-Wishbone arbiter sharing one slave
// (board memory / VRAM controller) between NUM_MASTERS requesters.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   m_cyc_i/m_stb_i/... : per-master requests (addr/data packed per index)
//   m_dat_o             : slave read data, broadcast to all masters
//   m_ack_o/err/stall   : per-master responses (only the owner sees slave)
//   s_*_o / s_*_i       : single slave port
//   grant_o             : one-hot owner, zero when idle
//
// Optional: define WB_ARB_TIMEOUT_EN to enable the watchdog that errors
// out a burst the slave has not answered within TIMEOUT_CYCLES cycles.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 3,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_MASTERS-1:0]        m_cyc_i,
   input  logic [NUM_MASTERS-1:0]        m_stb_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
   output logic [DATA_W-1:0]             m_dat_o,
   output logic [NUM_MASTERS-1:0]        m_ack_o,
   output logic [NUM_MASTERS-1:0]        m_err_o,
   output logic [NUM_MASTERS-1:0]        m_stall_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic                          s_we_o,
   output logic [ADDR_W-1:0]             s_adr_o,
   output logic [DATA_W-1:0]             s_dat_o,
   input  logic [DATA_W-1:0]             s_dat_i,
   input  logic                          s_ack_i,
   input  logic                          s_err_i,
   input  logic                          s_stall_i,
   output logic [NUM_MASTERS-1:0]        grant_o
);

   localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1)
   begin : g_bad_cfg
      $error("wb_rr_arbiter: unsupported parameter set");
   end

`ifdef WB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWNED = 2'd1,
      S_TERM  = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWNED = 2'd1
   } state_e;
`endif

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [LW-1:0]          last_q, last_d;
   logic [LW-1:0]          win;
   logic                   own_cyc;
   logic                   to_hit;

   // last_q doubles as the owner index while a burst is held
   assign own_cyc = m_cyc_i[last_q];
   assign grant_o = grant_q;
   assign m_dat_o = s_dat_i;

   // rotating search starting just after the previous winner
   always_comb begin
      logic       found;
      logic [LW:0] idx;
      found = 1'b0;
      win   = last_q;
      idx   = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = {1'b0, last_q} + (LW+1)'(k);
         if (idx >= (LW+1)'(NUM_MASTERS))
            idx = idx - (LW+1)'(NUM_MASTERS);
         if (!found && m_cyc_i[idx[LW-1:0]]) begin
            found = 1'b1;
            win   = idx[LW-1:0];
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;

   assign to_hit = (state_q == S_OWNED) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES));

   // pend tracks an accepted beat still awaiting its response
   always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (state_q != S_OWNED || s_ack_i || s_err_i) begin
         cnt_d  = '0;
         pend_d = 1'b0;
      end else begin
         if (s_stb_o && !s_stall_i)
            pend_d = 1'b1;
         if ((s_stb_o || pend_q) && !to_hit)
            cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         last_q  <= LW'(NUM_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         S_IDLE: begin
            if (|m_cyc_i) begin
               state_d      = S_OWNED;
               last_d       = win;
               grant_d      = '0;
               grant_d[win] = 1'b1;
            end
         end
         S_OWNED: begin
            if (!own_cyc) begin
               state_d = S_IDLE;
               grant_d = '0;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (to_hit) begin
               state_d = S_TERM;
            end
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         S_TERM: begin
            if (!own_cyc) begin
               state_d = S_IDLE;
               grant_d = '0;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // outputs: only the owner is connected to the slave
   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = '0;
      s_dat_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      m_stall_o = '1;
      if (state_q == S_OWNED) begin
         s_cyc_o = own_cyc;
         s_stb_o = own_cyc & m_stb_i[last_q];
         s_we_o  = m_we_i[last_q];
         s_adr_o = m_adr_i[int'(last_q)*ADDR_W +: ADDR_W];
         s_dat_o = m_dat_i[int'(last_q)*DATA_W +: DATA_W];
         m_ack_o[last_q]   = s_ack_i;
         m_err_o[last_q]   = s_err_i;
         m_stall_o[last_q] = s_stall_i;
         // watchdog fires: cut the slave off and error the owner
         if (to_hit) begin
            s_cyc_o           = 1'b0;
            s_stb_o           = 1'b0;
            m_ack_o[last_q]   = 1'b0;
            m_err_o[last_q]   = 1'b1;
            m_stall_o[last_q] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: random masters + directed cases, scoreboard on grants
// and a per-cycle reference of who should own the slave port.
module tb_wb_rr_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  m_cyc_i, m_stb_i, m_we_i;
   logic [N*AW-1:0] m_adr_i;
   logic [N*DW-1:0] m_dat_i;
   logic [DW-1:0] m_dat_o;
   logic [N-1:0]  m_ack_o, m_err_o, m_stall_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o, s_dat_i;
   logic          s_ack_i, s_err_i, s_stall_i;
   logic [N-1:0]  grant_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int own_m;
   int ptr_m;
   int exp_q[$];
   logic [N-1:0] prev_g;
   int beats[N];

   always #5 clk = ~clk;

   wb_rr_arbiter #(
      .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o),
      .m_stall_o(m_stall_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .s_stall_i(s_stall_i), .grant_o(grant_o)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference: owner index (-1 idle) and rotation pointer
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         own_m <= -1;
         ptr_m <= N - 1;
         exp_q.delete();
      end else if (own_m >= 0) begin
         if (!m_cyc_i[own_m]) own_m <= -1;
      end else if (m_cyc_i != '0) begin
         int w;
         int c;
         w = -1;
         for (int k = 1; k <= N; k++) begin
            c = (ptr_m + k) % N;
            if (w < 0 && m_cyc_i[c]) w = c;
         end
         own_m <= w;
         ptr_m <= w;
         exp_q.push_back(w);
      end
   end

   // monitor
   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic [N-1:0] gw;
      int w;
      if (!rst_n) begin
         prev_g <= '0;
      end else begin
         if (chk_en) begin
            eg = '0;
            if (own_m >= 0) eg[own_m] = 1'b1;
            chk("grant", grant_o, eg);
            chk("m_dat", m_dat_o, s_dat_i);
            if (own_m >= 0) begin
               chk("s_cyc", s_cyc_o, m_cyc_i[own_m]);
               chk("s_stb", s_stb_o,
                   m_cyc_i[own_m] & m_stb_i[own_m]);
               if (m_cyc_i[own_m]) begin
                  chk("s_adr", s_adr_o, m_adr_i[own_m*AW +: AW]);
                  chk("s_dat", s_dat_o, m_dat_i[own_m*DW +: DW]);
                  chk("s_we", s_we_o, m_we_i[own_m]);
               end
               chk("own_ack", m_ack_o[own_m], s_ack_i);
               chk("own_stall", m_stall_o[own_m], s_stall_i);
            end else begin
               chk("idle_s_cyc", s_cyc_o, 1'b0);
            end
            for (int i = 0; i < N; i++)
               if (i != own_m)
                  chk("nonown_resp",
                      {m_stall_o[i], m_ack_o[i], m_err_o[i]}, 3'b100);
            if (grant_o != '0 && prev_g == '0) begin
               if (exp_q.size() == 0) begin
                  chk("grant_unexpected", grant_o, '0);
               end else begin
                  w  = exp_q.pop_front();
                  gw = '0;
                  gw[w] = 1'b1;
                  chk("grant_order", grant_o, gw);
               end
            end
         end
         prev_g <= grant_o;
      end
   end

   task automatic rand_cycle(input bit allow_new);
      logic         acc_s;
      logic [N-1:0] accm, ackm;
      @(negedge clk);
      acc_s = s_cyc_o & s_stb_o & ~s_stall_i;
      accm  = m_cyc_i & m_stb_i & ~m_stall_o;
      ackm  = m_ack_o;
      @(posedge clk);
      #1;
      s_ack_i   = acc_s;
      s_stall_i = ($urandom_range(3) == 0);
      s_dat_i   = $urandom;
      for (int i = 0; i < N; i++) begin
         if (!m_cyc_i[i]) begin
            if (allow_new && $urandom_range(2) == 0) begin
               m_cyc_i[i] = 1'b1;
               m_stb_i[i] = 1'b1;
               m_we_i[i]  = 1'($urandom_range(1));
               beats[i]   = $urandom_range(3, 1);
               m_adr_i[i*AW +: AW] = $urandom;
               m_dat_i[i*DW +: DW] = $urandom;
            end
         end else begin
            if (accm[i]) m_stb_i[i] = 1'b0;
            if (ackm[i]) begin
               beats[i]--;
               if (beats[i] <= 0) begin
                  m_cyc_i[i] = 1'b0;
                  m_stb_i[i] = 1'b0;
               end else begin
                  m_stb_i[i] = 1'b1;
                  m_adr_i[i*AW +: AW] = $urandom;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int c;
      rst_n = 1'b0;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
      m_adr_i = '0; m_dat_i = '0;
      s_dat_i = 32'hDEADBEEF;
      s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0;
      #1;
      chk("rst_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
      chk("rst_s_adr", s_adr_o, '0);
      chk("rst_s_dat", s_dat_o, '0);
      chk("rst_grant", grant_o, '0);
      chk("rst_ack_err", {m_ack_o, m_err_o}, '0);
      chk("rst_stall", m_stall_o, 3'b111);
      chk("rst_m_dat", m_dat_o, 32'hDEADBEEF);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // stray responses while idle
      s_ack_i = 1'b1; s_err_i = 1'b1;
      #1;
      chk("stray_ack", m_ack_o, '0);
      chk("stray_err", m_err_o, '0);
      s_ack_i = 1'b0; s_err_i = 1'b0;

      // simultaneous requests from 0 and 1
      tick();
      m_adr_i[0 +: AW]  = 32'h10;
      m_adr_i[AW +: AW] = 32'h20;
      m_dat_i[0 +: DW]  = 32'hA5A5A5A5;
      m_dat_i[DW +: DW] = 32'h5A5A5A5A;
      m_cyc_i = 3'b011;
      m_stb_i = 3'b011;
      tick();
      chk("t1_grant", grant_o, 3'b001);
      chk("t1_adr", s_adr_o, 32'h10);
      chk("t1_dat", s_dat_o, 32'hA5A5A5A5);
      chk("t1_stall1", m_stall_o[1], 1'b1);
      tick();
      m_cyc_i[0] = 1'b0;
      m_stb_i[0] = 1'b0;
      #1 chk("t2_cyc_k", s_cyc_o, 1'b0);
      tick();
      chk("t2_cyc_k1", s_cyc_o, 1'b0);
      chk("t2_grant_gap", grant_o, '0);
      tick();
      chk("t2_grant", grant_o, 3'b010);
      chk("t2_adr", s_adr_o, 32'h20);
      m_cyc_i = '0;
      m_stb_i = '0;
      repeat (2) tick();

      // randomized traffic, then drain
      repeat (400) rand_cycle(1'b1);
      c = 0;
      while (m_cyc_i != '0 && c < 200) begin
         rand_cycle(1'b0);
         c++;
      end
      chk("drain", m_cyc_i, '0);
      s_ack_i = 1'b0; s_stall_i = 1'b0;
      m_stb_i = '0;
      repeat (2) tick();

      // pending request while master 2 owns the bus
      m_adr_i[2*AW +: AW] = 32'h300;
      m_cyc_i = 3'b100;
      m_stb_i = 3'b100;
      tick();
      chk("t4_grant2", grant_o, 3'b100);
      m_adr_i[0 +: AW] = 32'h0;
      m_cyc_i[0] = 1'b1;
      m_stb_i[0] = 1'b1;
      s_ack_i = 1'b1;
      repeat (3) begin
         tick();
         chk("t4_no_ack0", m_ack_o[0], 1'b0);
         chk("t4_adr", s_adr_o, 32'h300);
      end
      s_ack_i = 1'b0;
      m_cyc_i[2] = 1'b0;
      m_stb_i[2] = 1'b0;
      tick();
      chk("t4_gap", grant_o, '0);
      tick();
      chk("t4_grant0", grant_o, 3'b001);
      m_cyc_i = '0;
      m_stb_i = '0;
      repeat (2) tick();

      // async reset mid-burst
      m_cyc_i = 3'b010;
      m_stb_i = 3'b010;
      tick();
      chk("t6_grant1", grant_o, 3'b010);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_cyc", s_cyc_o, 1'b0);
      chk("t6_rst_grant", grant_o, '0);
      m_cyc_i = 3'b110;
      m_stb_i = 3'b110;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      chk("t6_first", grant_o, 3'b010);
      m_cyc_i = '0;
      m_stb_i = '0;
      repeat (2) tick();

`ifdef WB_ARB_TIMEOUT_EN
      // watchdog on a slave that never answers
      chk_en = 1'b0;
      s_ack_i = 1'b0;
      s_stall_i = 1'b0;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m_cyc_i = 3'b001;
      m_stb_i = 3'b001;
      tick();
      chk("to_first_stb", s_stb_o, 1'b1);
      n = -1;
      c = 0;
      while (n < 0 && c < 40) begin
         tick();
         c++;
         if (m_err_o[0]) begin
            n = c;
            chk("to_cyc_drop", s_cyc_o, 1'b0);
         end
      end
      chk("to_latency", n, TO);
      tick();
      chk("to_err_once", m_err_o[0], 1'b0);
      chk("to_term_cyc", s_cyc_o, 1'b0);
      m_cyc_i = 3'b010;
      m_stb_i = 3'b010;
      tick();
      chk("to_idle", grant_o, '0);
      tick();
      chk("to_next", grant_o, 3'b010);
      m_cyc_i = '0;
      m_stb_i = '0;
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone (pipelined) arbiter that shares one slave port, the board-memory/VRAM controller, between `NUM_MASTERS` requesters: display read, game logic and the init/mouse path. It replaces fixed-priority arbitration so that no master can starve another. Ownership is held for a whole `cyc` burst, with one idle bus cycle at every handover. An optional watchdog terminates bursts that the slave never acknowledges.

## Interface
Parameters:
- `NUM_MASTERS`, 3, number of requesters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 16, watchdog limit (used only with `WB_ARB_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `m_cyc_i` in NUM_MASTERS: per-master cycle request
- `m_stb_i` in NUM_MASTERS: per-master strobe
- `m_we_i` in NUM_MASTERS: per-master write enable
- `m_adr_i` in NUM_MASTERS*ADDR_W: packed addresses, master i at [i*ADDR_W +: ADDR_W]
- `m_dat_i` in NUM_MASTERS*DATA_W: packed write data
- `m_dat_o` out DATA_W: read data, broadcast to all masters
- `m_ack_o` / `m_err_o` / `m_stall_o` out NUM_MASTERS: per-master responses
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave control
- `s_adr_o` out ADDR_W: slave address
- `s_dat_o` out DATA_W: slave write data
- `s_dat_i` in DATA_W: slave read data
- `s_ack_i`, `s_err_i`, `s_stall_i` in 1: slave responses
- `grant_o` out NUM_MASTERS: one-hot current owner, all zeros when idle

## Operation
- FSM states: IDLE, OWNED, TERM (TERM is reachable only with the timeout feature).
- **IDLE:**
  - If any `m_cyc_i` bit is set, the next edge registers `grant_o` to the first requester found by searching from `last+1` upward with wrap-around.
  - `last` is set to the granted index and the FSM enters OWNED.
  - With no request, the FSM stays in IDLE.
- **OWNED:**
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o` and `s_dat_o` are driven combinationally from the owner's inputs.
  - `m_ack_o`, `m_err_o` and `m_stall_o` for the owner are driven combinationally from `s_ack_i`, `s_err_i` and `s_stall_i`.
- **Non-owners:** `m_stall_o`=1, `m_ack_o`=0, `m_err_o`=0 at all times. Their `stb` is never forwarded.
- **Release:** when the owner drops `m_cyc_i`, the next edge clears `grant_o` and returns the FSM to IDLE. Re-arbitration happens on the following edge.
- **Stray responses:** a slave ack or err arriving while idle is dropped.
- `m_dat_o` = `s_dat_i` at all times.
- **Reset:** asserting `rst_n` low mid-burst immediately drives `grant_o`=0, the FSM to IDLE and `last`=NUM_MASTERS-1, so master 0 wins the first arbitration after reset. Slave outputs go to 0 asynchronously.

## Timing
- **Reset values:** all `s_*_o` = 0; `grant_o` = 0; `m_ack_o` = 0; `m_err_o` = 0; `m_stall_o` = all ones; `m_dat_o` = `s_dat_i`.
- **Grant latency:** a `cyc` sampled in IDLE at edge N gives `grant_o` and the forwarded `s_stb_o` at edge N+1.
- **Handover:** the owner drops `cyc` in cycle k. `s_cyc_o` is low in cycles k and k+1, and the next owner drives the bus from cycle k+2.
- **Response path:** ack, err and stall take 0 cycles (combinational pass-through) for the owner only.
- **Simultaneous requests:** only the rotation pointer decides. There is no fixed priority.
- **Request during a burst:** held pending until handover. The pending master's `m_stall_o` stays 1 throughout.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A counter runs in OWNED while `s_stb_o`=1 or a request is outstanding without `s_ack_i`/`s_err_i`. It clears on ack, on err, or on ownership change.
  - When the counter reaches `TIMEOUT_CYCLES`, the owner gets `m_err_o`=1 for exactly one cycle and the FSM enters TERM.
  - In TERM: `s_cyc_o`=0, `s_stb_o`=0, owner `m_stall_o`=1. The FSM stays in TERM until the owner drops `cyc`, then goes to IDLE.
- Undefined: no counter and no TERM state. A stuck slave holds the bus indefinitely.

## Test plan
1. Release reset, then raise masters 0 and 1 together (adr 0x10 / 0x20, dat 0xA5A5A5A5 / 0x5A5A5A5A) -> one edge later `grant_o`=001, `s_adr_o`=0x10, `s_dat_o`=0xA5A5A5A5; master 1 sees `m_stall_o`=1.
2. Master 0 drops `cyc` -> `s_cyc_o` low for 2 cycles, then `grant_o`=010 and `s_adr_o`=0x20.
3. All three masters issue back-to-back single-beat bursts with the slave acking each `stb` after 1 cycle -> grant order 0,1,2,0,1,2 with no master granted twice in a row.
4. While master 2 owns the bus, master 0 issues a `stb` -> master 0 never sees an ack, the slave never sees adr 0, and master 0 gets the bus only after master 2 releases.
5. `WB_ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=16, slave never acks -> owner gets `m_err_o` exactly 16 cycles after the first `stb` and `s_cyc_o` drops the same cycle. After the owner drops `cyc`, the next requester is granted.
6. Pull `rst_n` low mid-burst while master 1 owns the bus -> `s_cyc_o` and `grant_o` go to 0 without waiting for a clock edge. After release, with masters 1 and 2 requesting, master 1 is granted first.
